// File: rtl/stopwatch_display_scan.sv
// Four-digit multiplexed seven-segment driver for the stopwatch BCD chain.
// Digits are snapshotted once per frame so a carry mid-scan never shows torn.
module stopwatch_display_scan #(
    parameter int SCAN_DIV       = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] min1,
    input  logic [3:0] sec10,
    input  logic [3:0] sec1,
    input  logic [3:0] ms100,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int              PCNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]      AN_OFF   = {4{AN_ACTIVE_LOW}};
    localparam logic [6:0]      SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic            DP_OFF   = SEG_ACTIVE_LOW;

    logic [PCNT_W-1:0] r_pcnt;
    logic [1:0]        r_idx;
    logic [3:0]        r_sh_min1, r_sh_sec10, r_sh_sec1, r_sh_ms100;
    logic              w_tick;
    logic [3:0]        w_digit;
    logic              w_blank_slot;
    logic [3:0]        w_an_on;
    logic [6:0]        w_seg_on;
    logic              w_dp_on;

    // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD values show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = 7'h40;
        endcase
    endfunction

    assign w_tick = (r_pcnt == PCNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt     <= '0;
            r_idx      <= 2'd0;
            r_sh_min1  <= 4'd0;
            r_sh_sec10 <= 4'd0;
            r_sh_sec1  <= 4'd0;
            r_sh_ms100 <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            r_pcnt     <= w_tick ? '0 : r_pcnt + 1'b1;
            frame_done <= w_tick && (r_idx == 2'd3);
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
                // End of the leftmost slot closes the frame: take a coherent copy.
                if (r_idx == 2'd3) begin
                    r_sh_min1  <= min1;
                    r_sh_sec10 <= sec10;
                    r_sh_sec1  <= sec1;
                    r_sh_ms100 <= ms100;
                end
            end
        end
    end

    always_comb begin
        w_digit = r_sh_ms100;
        case (r_idx)
            2'd0: w_digit = r_sh_ms100;
            2'd1: w_digit = r_sh_sec1;
            2'd2: w_digit = r_sh_sec10;
            2'd3: w_digit = r_sh_min1;
            default: w_digit = r_sh_ms100;
        endcase
    end

    assign w_blank_slot = blank_lz && (r_idx == 2'd3) && (r_sh_min1 == 4'd0);

    always_comb begin
        w_an_on  = 4'b0001 << r_idx;
        w_seg_on = bcd_to_seg(w_digit);
        w_dp_on  = dp_mask[r_idx];
        if (w_blank_slot) begin
            w_an_on  = 4'b0000;
            w_seg_on = 7'h00;
            w_dp_on  = 1'b0;
        end
        if (!en) begin
            w_an_on = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end else begin
            an  <= w_an_on ^ AN_OFF;
            seg <= w_seg_on ^ SEG_OFF;
            dp  <= w_dp_on ^ DP_OFF;
        end
    end

endmodule
